// File: rtl/sum_display_scan.sv
// Registers a binary sum, converts it to BCD one shift per clock (double dabble),
// and scans the decimal digits onto a 4-digit common-anode seven-segment display.
module sum_display_scan #(
    parameter int DATA_W      = 5,
    parameter int REFRESH_DIV = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] sum_in,
    input  logic              load,
    output logic              busy,
    output logic [3:0]        an,
    output logic [6:0]        seg
);
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int SW = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_COMMIT} state_t;

    state_t               r_state;
    logic [15+DATA_W:0]   r_sr;      // {bcd[15:0], bin[DATA_W-1:0]}
    logic [SW-1:0]        r_shift;
    logic [3:0][3:0]      r_dig;
    logic [RW-1:0]        r_refresh;
    logic [1:0]           r_idx;
    logic                 r_busy;
    logic [3:0]           r_an;
    logic [6:0]           r_seg;

    logic [15:0]          w_adj;
    logic [3:0]           w_blank;
    logic                 w_tick;

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_adj
            assign w_adj[4*g +: 4] = (r_sr[DATA_W + 4*g +: 4] >= 4'd5)
                                   ? r_sr[DATA_W + 4*g +: 4] + 4'd3
                                   : r_sr[DATA_W + 4*g +: 4];
        end
    endgenerate

    // A digit is blank when it and every digit above it are zero; digit 0 always shows.
    assign w_blank[3] = (r_dig[3] == 4'd0);
    assign w_blank[2] = w_blank[3] && (r_dig[2] == 4'd0);
    assign w_blank[1] = w_blank[2] && (r_dig[1] == 4'd0);
    assign w_blank[0] = 1'b0;

    assign w_tick = (r_refresh == RW'(REFRESH_DIV - 1));

    function automatic logic [6:0] f_seg(input logic [3:0] d);
        case (d)
            4'd0:    f_seg = 7'h40;
            4'd1:    f_seg = 7'h79;
            4'd2:    f_seg = 7'h24;
            4'd3:    f_seg = 7'h30;
            4'd4:    f_seg = 7'h19;
            4'd5:    f_seg = 7'h12;
            4'd6:    f_seg = 7'h02;
            4'd7:    f_seg = 7'h78;
            4'd8:    f_seg = 7'h00;
            4'd9:    f_seg = 7'h10;
            default: f_seg = 7'h7F;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_sr      <= '0;
            r_shift   <= '0;
            r_dig     <= '0;
            r_refresh <= '0;
            r_idx     <= 2'd0;
            r_busy    <= 1'b0;
            r_an      <= 4'b1111;
            r_seg     <= 7'h7F;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (load) begin
                        r_sr    <= {16'd0, sum_in};
                        r_shift <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_CONVERT;
                    end
                end
                S_CONVERT: begin
                    r_sr    <= {w_adj, r_sr[DATA_W-1:0]} << 1;
                    r_shift <= r_shift + 1'b1;
                    if (r_shift == SW'(DATA_W - 1))
                        r_state <= S_COMMIT;
                end
                S_COMMIT: begin
                    r_dig   <= r_sr[DATA_W +: 16];
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_tick) begin
                r_refresh <= '0;
                r_an      <= ~(4'b0001 << r_idx);
                r_seg     <= w_blank[r_idx] ? 7'h7F : f_seg(r_dig[r_idx]);
                r_idx     <= r_idx + 2'd1;
            end else begin
                r_refresh <= r_refresh + 1'b1;
            end
        end
    end

    assign busy = r_busy;
    assign an   = r_an;
    assign seg  = r_seg;
endmodule

// File: tb/tb_sum_display_scan.sv
// Self-checking bench for sum_display_scan: directed tables, corner sequences and
// randomized loads checked against an arithmetic decimal-display model.
module tb_sum_display_scan;
    localparam int DATA_W = 5;
    localparam int REFRESH_DIV = 4;

    logic              clk;
    logic              rst_n;
    logic [DATA_W-1:0] sum_in;
    logic              load;
    logic              busy;
    logic [3:0]        an;
    logic [6:0]        seg;

    int n_cmp;
    int n_bad;

    logic [6:0] segtab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    logic [6:0] got_seg [4];

    typedef struct {
        int              val;
        logic [3:0][6:0] exp;   // exp[i] = segment code of digit i
    } vec_t;
    vec_t tbl [8];

    sum_display_scan #(.DATA_W(DATA_W), .REFRESH_DIV(REFRESH_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .sum_in(sum_in), .load(load),
        .busy(busy), .an(an), .seg(seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Decimal digit i of v, blank when v has fewer than i+1 digits.
    function automatic logic [6:0] model_seg(input int v, input int i);
        int p;
        p = (i == 0) ? 1 : (i == 1) ? 10 : (i == 2) ? 100 : 1000;
        if (i > 0 && v < p) return 7'h7F;
        return segtab[(v / p) % 10];
    endfunction

    task automatic wait_idle(output int n);
        n = 0;
        while (busy !== 1'b0 && n < 50) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic do_load(input int v, output int nbusy);
        sum_in = DATA_W'(v);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        sum_in = DATA_W'($urandom);
        wait_idle(nbusy);
    endtask

    // Collect one full scan of the four digit slots that starts after this point.
    task automatic read_slots(output logic ok);
        logic [3:0] prev;
        logic [3:0] mask;
        int idx;
        prev = an;
        mask = 4'h0;
        ok = 1'b1;
        for (int c = 0; c < 60 && mask != 4'hF; c++) begin
            @(negedge clk);
            if (an !== prev) begin
                prev = an;
                case (an)
                    4'b1110: idx = 0;
                    4'b1101: idx = 1;
                    4'b1011: idx = 2;
                    4'b0111: idx = 3;
                    default: idx = -1;
                endcase
                if (idx < 0) ok = 1'b0;
                else begin
                    got_seg[idx] = seg;
                    mask[idx] = 1'b1;
                end
            end
        end
        if (mask != 4'hF) ok = 1'b0;
    endtask

    task automatic check_display(input string tag, input int v);
        logic ok;
        read_slots(ok);
        chk({tag, " scan"}, {31'd0, ok}, 32'd1);
        for (int i = 0; i < 4; i++)
            chk($sformatf("%s dig%0d v=%0d", tag, i, v), {25'd0, got_seg[i]}, {25'd0, model_seg(v, i)});
    endtask

    initial begin
        int n;
        int gap;
        logic ok;
        logic [3:0] prev_an;
        int run;
        logic seen;

        n_cmp = 0;
        n_bad = 0;
        tbl[0] = '{0,  {7'h7F, 7'h7F, 7'h7F, 7'h40}};
        tbl[1] = '{7,  {7'h7F, 7'h7F, 7'h7F, 7'h78}};
        tbl[2] = '{10, {7'h7F, 7'h7F, 7'h79, 7'h40}};
        tbl[3] = '{25, {7'h7F, 7'h7F, 7'h24, 7'h12}};
        tbl[4] = '{31, {7'h7F, 7'h7F, 7'h30, 7'h79}};
        tbl[5] = '{20, {7'h7F, 7'h7F, 7'h24, 7'h40}};
        tbl[6] = '{18, {7'h7F, 7'h7F, 7'h79, 7'h00}};
        tbl[7] = '{29, {7'h7F, 7'h7F, 7'h24, 7'h10}};

        rst_n = 1'b0;
        load = 1'b0;
        sum_in = '0;

        // 1: reset hold, then first tick on the 4th edge after release
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst busy", {31'd0, busy}, 32'd0);
            chk("rst an", {28'd0, an}, 32'hF);
            chk("rst seg", {25'd0, seg}, 32'h7F);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("pre-tick an", {28'd0, an}, 32'hF);
        end
        @(negedge clk);
        chk("first tick an", {28'd0, an}, 32'hE);
        chk("first tick seg", {25'd0, seg}, 32'h40);

        // 2: load 31, busy exactly DATA_W+1 cycles
        do_load(31, n);
        chk("busy len 31", n, DATA_W + 1);
        check_display("t2", 31);

        // 3: load during busy is ignored
        sum_in = 5'd9;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        sum_in = 5'd17;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_idle(n);
        chk("busy len ignore", n + 2, DATA_W + 1);
        check_display("t3", 9);

        // 4: reset aborts a conversion
        sum_in = 5'd16;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort an", {28'd0, an}, 32'hF);
        rst_n = 1'b1;
        do_load(0, n);
        chk("busy len 0", n, DATA_W + 1);
        check_display("t4", 0);

        // 5: free-run scan order, one-hot anodes, 4-cycle slots
        prev_an = an;
        run = 1;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            chk("onehot", $countones(~an), 1);
            if (an === prev_an) run++;
            else begin
                if (seen) chk("slot hold", run, REFRESH_DIV);
                chk("scan order", {28'd0, an}, {28'd0, prev_an[2:0], prev_an[3]});
                seen = 1'b1;
                run = 1;
                prev_an = an;
            end
        end

        // 6: load held high, reload on first idle cycle
        sum_in = 5'd16;
        load = 1'b1;
        @(negedge clk);
        wait_idle(n);
        chk("busy len held", n, DATA_W + 1);
        gap = 0;
        while (busy === 1'b0 && gap < 10) begin
            gap++;
            @(negedge clk);
        end
        chk("busy gap", gap, 1);
        load = 1'b0;
        wait_idle(n);
        check_display("t6", 16);

        // table-driven vectors
        for (int k = 0; k < 8; k++) begin
            do_load(tbl[k].val, n);
            chk($sformatf("tbl busy v=%0d", tbl[k].val), n, DATA_W + 1);
            read_slots(ok);
            chk("tbl scan", {31'd0, ok}, 32'd1);
            for (int i = 0; i < 4; i++)
                chk($sformatf("tbl v=%0d dig%0d", tbl[k].val, i),
                    {25'd0, got_seg[i]}, {25'd0, tbl[k].exp[i]});
        end

        // randomized loads vs arithmetic model
        for (int k = 0; k < 20; k++) begin
            int v;
            v = $urandom_range(0, 31);
            do_load(v, n);
            chk("rnd busy", n, DATA_W + 1);
            check_display("rnd", v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
